// File: rtl/mem_wb_stage.sv
// M->W pipeline stage: data-memory access over a req/ack bus and write-back register.
// Optional access timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_wb_stage
`ifdef MEM_TIMEOUT_EN
  #(
    parameter int unsigned TIMEOUT_CYCLES = 16
  )
`endif
  (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    input  logic [31:0] PCPlus4M,
    input  logic        JalM,
    output logic        DMemReq,
    output logic        DMemWe,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    input  logic [31:0] DMemRData,
    input  logic        DMemAck,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [4:0]  WriteRegW,
    output logic [31:0] ResultW,
    output logic        AlignErr,
    output logic        MemErr
  );

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_addr, r_wdata;
  logic        r_we, r_rw, r_mtr;
  logic [4:0]  r_rd;
  logic        r_rw_w, r_align;
  logic [4:0]  r_rd_w;
  logic [31:0] r_res_w;

  logic        w_memop, w_misalign, w_issue, w_timeout, w_capture;
  logic        w_wb_full, w_wb_rw;
  logic [4:0]  w_wb_rd;
  logic [31:0] w_wb_res;

  assign w_memop    = MemtoRegM | MemWriteM;
  assign w_misalign = w_memop & (ALUOutM[1:0] != 2'b00);
  assign w_issue    = (r_state == StIdle) & w_memop & ~w_misalign & ~reset;

`ifdef MEM_TIMEOUT_EN
  logic [4:0] r_cnt;
  logic       r_memerr;

  assign w_timeout = (r_state == StWait) & ~DMemAck & (r_cnt == 5'(TIMEOUT_CYCLES - 1));
  assign MemErr    = r_memerr;

  // Counter is held at zero while idle, so it always starts from zero on WAIT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_memerr <= 1'b0;
    end else begin
      if (r_state == StIdle) r_cnt <= 5'd0;
      else if (!DMemAck)     r_cnt <= r_cnt + 5'd1;
      if (w_timeout) r_memerr <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign MemErr    = 1'b0;
`endif

  always_comb begin
    DMemReq   = 1'b0;
    DMemWe    = 1'b0;
    DMemAddr  = 32'd0;
    DMemWData = 32'd0;
    if (r_state == StWait) begin
      DMemReq   = 1'b1;
      DMemWe    = r_we;
      DMemAddr  = r_addr;
      DMemWData = r_wdata;
    end else if (w_issue) begin
      DMemReq   = 1'b1;
      DMemWe    = MemWriteM;
      DMemAddr  = {ALUOutM[31:2], 2'b00};
      DMemWData = WriteDataM;
    end
  end

  assign StallM = ~reset & ~DMemAck & (w_issue | ((r_state == StWait) & ~w_timeout));

  // A bubble clears RegWriteW only; the data fields keep their last value.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_wb_full    = 1'b0;
    w_wb_rw      = 1'b0;
    w_wb_rd      = WriteRegM;
    w_wb_res     = ALUOutM;
    case (r_state)
      StIdle: begin
        if (!w_memop) begin
          w_wb_full = 1'b1;
          w_wb_rw   = RegWriteM;
          w_wb_res  = JalM ? PCPlus4M : ALUOutM;
        end else if (w_misalign) begin
          w_wb_full = 1'b0;
        end else if (DMemAck) begin
          w_wb_full = 1'b1;
          w_wb_rw   = RegWriteM & ~MemWriteM;
          w_wb_res  = JalM ? PCPlus4M : (MemWriteM ? ALUOutM : DMemRData);
        end else begin
          w_capture    = 1'b1;
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (DMemAck) begin
          w_wb_full    = 1'b1;
          w_wb_rw      = r_rw & ~r_we;
          w_wb_rd      = r_rd;
          w_wb_res     = (r_mtr & ~r_we) ? DMemRData : r_addr;
          w_state_next = StIdle;
        end else if (w_timeout) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_we    <= 1'b0;
      r_rw    <= 1'b0;
      r_mtr   <= 1'b0;
      r_rd    <= 5'd0;
      r_rw_w  <= 1'b0;
      r_rd_w  <= 5'd0;
      r_res_w <= 32'd0;
      r_align <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_addr  <= {ALUOutM[31:2], 2'b00};
        r_wdata <= WriteDataM;
        r_we    <= MemWriteM;
        r_rw    <= RegWriteM;
        r_mtr   <= MemtoRegM;
        r_rd    <= WriteRegM;
      end
      r_rw_w <= w_wb_rw;
      if (w_wb_full) begin
        r_rd_w  <= w_wb_rd;
        r_res_w <= w_wb_res;
      end
      if ((r_state == StIdle) && w_misalign) r_align <= 1'b1;
    end
  end

  assign RegWriteW = r_rw_w;
  assign WriteRegW = r_rd_w;
  assign ResultW   = r_res_w;
  assign AlignErr  = r_align;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: transaction-level model checked every cycle plus
// directed vectors with literal expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0, JalM = 1'b0;
  logic [31:0] ALUOutM = '0, WriteDataM = '0, PCPlus4M = '0, DMemRData = '0;
  logic [4:0]  WriteRegM = '0;
  logic        DMemAck = 1'b0;
  logic        DMemReq, DMemWe, StallM, RegWriteW, AlignErr, MemErr;
  logic [31:0] DMemAddr, DMemWData, ResultW;
  logic [4:0]  WriteRegW;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
    .PCPlus4M(PCPlus4M), .JalM(JalM), .DMemReq(DMemReq), .DMemWe(DMemWe),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemRData(DMemRData), .DMemAck(DMemAck),
    .StallM(StallM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .AlignErr(AlignErr), .MemErr(MemErr)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an outstanding access is either absent or described by the m_* fields.
  localparam int Tmo = 16;
  bit          m_pend = 0, m_store = 0, m_rw = 0;
  bit [4:0]    m_rd = '0;
  bit [31:0]   m_addr = '0, m_wdata = '0;
  int          m_waits = 0;
  bit          e_rw = 0, e_chk = 1, e_align = 0, e_err = 0;
  bit [4:0]    e_rd = '0;
  bit [31:0]   e_res = '0;

  always @(negedge clk) begin
    bit memop;
    chk("m RegWriteW", 32'(RegWriteW), 32'(e_rw));
    if (e_chk) begin
      chk("m WriteRegW", 32'(WriteRegW), 32'(e_rd));
      chk("m ResultW", ResultW, e_res);
    end
    chk("m AlignErr", 32'(AlignErr), 32'(e_align));
    chk("m MemErr", 32'(MemErr), 32'(e_err));
    if (reset) begin
      m_pend = 0; e_rw = 0; e_rd = '0; e_res = '0; e_chk = 1; e_align = 0; e_err = 0;
    end else begin
      memop = MemtoRegM | MemWriteM;
      if (m_pend) begin
        chk("m DMemReq", 32'(DMemReq), 32'd1);
        chk("m DMemAddr", DMemAddr, m_addr);
        chk("m DMemWe", 32'(DMemWe), 32'(m_store));
        chk("m DMemWData", DMemWData, m_wdata);
        if (DMemAck) begin
          chk("m StallM", 32'(StallM), 32'd0);
          e_rw = m_rw && !m_store; e_rd = m_rd; e_res = DMemRData; e_chk = e_rw; m_pend = 0;
        end
`ifdef MEM_TIMEOUT_EN
        else if (m_waits == Tmo - 1) begin
          chk("m StallM", 32'(StallM), 32'd0);
          e_rw = 0; e_chk = 0; e_err = 1; m_pend = 0;
        end
`endif
        else begin
          chk("m StallM", 32'(StallM), 32'd1);
          e_rw = 0; e_chk = 0; m_waits++;
        end
      end else if (memop && ALUOutM[1:0] == 2'b00) begin
        chk("m DMemReq", 32'(DMemReq), 32'd1);
        chk("m DMemAddr", DMemAddr, {ALUOutM[31:2], 2'b00});
        chk("m DMemWe", 32'(DMemWe), 32'(MemWriteM));
        chk("m DMemWData", DMemWData, WriteDataM);
        if (DMemAck) begin
          chk("m StallM", 32'(StallM), 32'd0);
          e_rw = RegWriteM && !MemWriteM; e_rd = WriteRegM;
          e_res = JalM ? PCPlus4M : (MemWriteM ? ALUOutM : DMemRData); e_chk = e_rw;
        end else begin
          chk("m StallM", 32'(StallM), 32'd1);
          m_pend = 1; m_addr = {ALUOutM[31:2], 2'b00}; m_store = MemWriteM;
          m_wdata = WriteDataM; m_rw = RegWriteM; m_rd = WriteRegM; m_waits = 0;
          e_rw = 0; e_chk = 0;
        end
      end else begin
        chk("m DMemReq", 32'(DMemReq), 32'd0);
        chk("m StallM", 32'(StallM), 32'd0);
        if (memop) begin
          e_align = 1; e_rw = 0; e_chk = 0;
        end else begin
          e_rw = RegWriteM; e_rd = WriteRegM; e_res = JalM ? PCPlus4M : ALUOutM; e_chk = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rw, input bit mtr, input bit mw, input bit [31:0] alu,
                       input bit [31:0] wd, input bit [4:0] rd, input bit [31:0] pc4,
                       input bit jal, input bit ack, input bit [31:0] rdata);
    RegWriteM = rw; MemtoRegM = mtr; MemWriteM = mw; ALUOutM = alu; WriteDataM = wd;
    WriteRegM = rd; PCPlus4M = pc4; JalM = jal; DMemAck = ack; DMemRData = rdata;
  endtask

  task automatic nop();
    drive(0, 0, 0, 32'd0, 32'd0, 5'd0, 32'd0, 0, 0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst WriteRegW", 32'(WriteRegW), 32'd0);
    chk("rst ResultW", ResultW, 32'd0);
    chk("rst AlignErr", 32'(AlignErr), 32'd0);
    chk("rst DMemReq", 32'(DMemReq), 32'd0);
    chk("rst DMemAddr", DMemAddr, 32'd0);

    // ALU op and jal
    drive(1, 0, 0, 32'h2A, 32'd0, 5'd5, 32'd0, 0, 0, 32'd0);
    step();
    chk("alu RegWriteW", 32'(RegWriteW), 32'd1);
    chk("alu WriteRegW", 32'(WriteRegW), 32'd5);
    chk("alu ResultW", ResultW, 32'h2A);
    drive(1, 0, 0, 32'h77, 32'd0, 5'd31, 32'h1004, 1, 0, 32'd0);
    step();
    chk("jal ResultW", ResultW, 32'h1004);

    // Load acked after three stall cycles; upstream change during WAIT ignored
    drive(1, 1, 0, 32'h100, 32'd0, 5'd7, 32'd0, 0, 0, 32'd0);
    #1;
    chk("ld StallM c0", 32'(StallM), 32'd1);
    chk("ld DMemAddr c0", DMemAddr, 32'h100);
    step();
    drive(1, 1, 0, 32'h200, 32'd0, 5'd12, 32'd0, 0, 0, 32'd0);
    #1;
    chk("ld bubble c1", 32'(RegWriteW), 32'd0);
    chk("ld DMemAddr c1", DMemAddr, 32'h100);
    step();
    chk("ld StallM c2", 32'(StallM), 32'd1);
    step();
    DMemAck = 1'b1; DMemRData = 32'hDEADBEEF;
    #1;
    chk("ld StallM ack", 32'(StallM), 32'd0);
    chk("ld DMemAddr ack", DMemAddr, 32'h100);
    step();
    nop();
    chk("ld ResultW", ResultW, 32'hDEADBEEF);
    chk("ld WriteRegW", 32'(WriteRegW), 32'd7);
    chk("ld RegWriteW", 32'(RegWriteW), 32'd1);

    // Zero-wait store, zero-wait load, load+store treated as store
    drive(0, 0, 1, 32'h40, 32'h55, 5'd0, 32'd0, 0, 1, 32'd0);
    #1;
    chk("st DMemWe", 32'(DMemWe), 32'd1);
    chk("st DMemWData", DMemWData, 32'h55);
    chk("st StallM", 32'(StallM), 32'd0);
    step();
    chk("st RegWriteW", 32'(RegWriteW), 32'd0);
    drive(1, 1, 0, 32'h84, 32'd0, 5'd9, 32'd0, 0, 1, 32'h12345678);
    step();
    chk("ld0 ResultW", ResultW, 32'h12345678);
    drive(1, 1, 1, 32'h10, 32'hAA, 5'd4, 32'd0, 0, 1, 32'hFFFF0000);
    #1;
    chk("both DMemWe", 32'(DMemWe), 32'd1);
    step();
    chk("both RegWriteW", 32'(RegWriteW), 32'd0);

    // Misaligned load, then sticky flag
    drive(1, 1, 0, 32'h102, 32'd0, 5'd6, 32'd0, 0, 0, 32'd0);
    #1;
    chk("mis DMemReq", 32'(DMemReq), 32'd0);
    step();
    chk("mis AlignErr", 32'(AlignErr), 32'd1);
    chk("mis RegWriteW", 32'(RegWriteW), 32'd0);
    drive(1, 0, 0, 32'h33, 32'd0, 5'd2, 32'd0, 0, 0, 32'd0);
    step();
    chk("mis sticky", 32'(AlignErr), 32'd1);

    // Stray ack with no request is ignored
    drive(1, 0, 0, 32'h5, 32'd0, 5'd3, 32'd0, 0, 1, 32'h999);
    step();
    chk("stray ResultW", ResultW, 32'h5);

    // Reset during the second WAIT cycle abandons the access
    drive(1, 1, 0, 32'h300, 32'd0, 5'd8, 32'd0, 0, 0, 32'd0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    nop();
    #1;
    chk("rst2 DMemReq", 32'(DMemReq), 32'd0);
    chk("rst2 ResultW", ResultW, 32'd0);
    chk("rst2 AlignErr", 32'(AlignErr), 32'd0);
    DMemAck = 1'b1; DMemRData = 32'hBAD;
    step();
    nop();
    chk("rst2 late ack", 32'(RegWriteW), 32'd0);
    drive(1, 0, 0, 32'h1234, 32'd0, 5'd10, 32'd0, 0, 0, 32'd0);
    step();
    chk("rst2 alu", ResultW, 32'h1234);

    drive(1, 1, 0, 32'h500, 32'd0, 5'd11, 32'd0, 0, 0, 32'd0);
    step();
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i < Tmo; i++) begin
      chk("tmo StallM", 32'(StallM), 32'd1);
      step();
    end
    chk("tmo StallM last", 32'(StallM), 32'd0);
    step();
    nop();
    #1;
    chk("tmo MemErr", 32'(MemErr), 32'd1);
    chk("tmo DMemReq", 32'(DMemReq), 32'd0);
    chk("tmo RegWriteW", 32'(RegWriteW), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      chk("hold StallM", 32'(StallM), 32'd1);
      step();
    end
    DMemAck = 1'b1; DMemRData = 32'hCAFEF00D;
    step();
    nop();
    chk("hold ResultW", ResultW, 32'hCAFEF00D);
    chk("hold MemErr", 32'(MemErr), 32'd0);
`endif
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
